qtz_seg_fetch_ctrl: RTL and testbench



---
 rtl/hdc_pkg.sv | 23 ++
 rtl/qtz_lane.sv | 39 +++
 rtl/qtz_seg_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_qtz_seg_fetch_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared constants, level index type and controller state encoding for the HDC front end.
package hdc_pkg;

  localparam int FEATURE_COUNT   = 617;
  localparam int FEATURES_PER_CC = 62;
  localparam int SEG_COUNT       = (FEATURE_COUNT + FEATURES_PER_CC - 1) / FEATURES_PER_CC;
  localparam int FEAT_W          = 8;
  localparam int LEVEL_W         = 5;
  localparam int SEL_W           = 4;

  // First lane of the final beat that lies beyond FEATURE_COUNT.
  localparam int PAD_FIRST_LANE  = FEATURE_COUNT - (SEG_COUNT - 1) * FEATURES_PER_CC;

  typedef logic [LEVEL_W-1:0] level_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } qtz_state_e;

endpackage

// File: rtl/qtz_lane.sv
// One-lane feature quantizer with pad masking for lanes past FEATURE_COUNT.
// QTZ_ROUND_EN selects round-to-nearest with saturation instead of truncation.
module qtz_lane
  import hdc_pkg::*;
#(
  parameter int LANE_IDX = 0
) (
  input  logic [FEAT_W-1:0] feat_i,
  input  logic              last_seg_i,
  output level_idx_t        level_o
);

  localparam bit IS_PAD_LANE = (LANE_IDX >= PAD_FIRST_LANE);

  level_idx_t lvl;

`ifdef QTZ_ROUND_EN
  if (FEAT_W == LEVEL_W) begin : g_ident
    assign lvl = feat_i;
  end else begin : g_round
    localparam int SH = FEAT_W - LEVEL_W;
    localparam logic [FEAT_W:0] HALF = (FEAT_W + 1)'(1) << (SH - 1);
    localparam logic [FEAT_W:0] MAXL = {{(FEAT_W + 1 - LEVEL_W){1'b0}}, {LEVEL_W{1'b1}}};
    logic [FEAT_W:0] sum;
    logic [FEAT_W:0] shifted;
    // One extra bit keeps the rounding carry so saturation can see it.
    assign sum     = {1'b0, feat_i} + HALF;
    assign shifted = sum >> SH;
    assign lvl     = (shifted > MAXL) ? {LEVEL_W{1'b1}} : shifted[LEVEL_W-1:0];
  end
`else
  logic unused_lsbs;
  assign unused_lsbs = ^feat_i;
  assign lvl = feat_i[FEAT_W-1 -: LEVEL_W];
`endif

  assign level_o = (last_seg_i && IS_PAD_LANE) ? '0 : lvl;

endmodule

// File: rtl/qtz_seg_fetch_ctrl.sv
// Sample beat intake, quantization to IM level indices, and latency-aligned segment writes.
// Optional macro QTZ_ROUND_EN (in qtz_lane) switches truncation to rounding.
module qtz_seg_fetch_ctrl
  import hdc_pkg::*;
#(
  parameter int IM_LAT = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FEAT_W*FEATURES_PER_CC-1:0] in_features,
  output logic                              im_req,
  output logic [LEVEL_W-1:0]                im_addr [0:FEATURES_PER_CC-1],
  output logic                              mapping_hv_segment,
  output logic [SEL_W-1:0]                  sel,
  output logic                              busy,
  output logic                              levels_ready
);

  if (SEG_COUNT > 16) begin : g_seg_chk
    $error("SEG_COUNT does not fit the 4-bit sel output");
  end
  if (FEAT_W < LEVEL_W) begin : g_width_chk
    $error("FEAT_W must be at least LEVEL_W");
  end
  if (IM_LAT < 1) begin : g_lat_chk
    $error("IM_LAT must be at least 1");
  end

  qtz_state_e          state_q;
  logic [SEL_W-1:0]    seg_cnt_q;
  logic                in_ready_q;
  logic                im_req_q;
  level_idx_t          im_addr_q [FEATURES_PER_CC];
  logic [IM_LAT-1:0]   pipe_v_q;
  logic [SEL_W-1:0]    pipe_s_q [IM_LAT];
  logic                map_q;
  logic [SEL_W-1:0]    sel_q;
  logic                busy_q;
  logic                levels_ready_q;

  level_idx_t          quant_lvl [FEATURES_PER_CC];
  logic                last_seg;
  logic                hs;

  assign last_seg = (seg_cnt_q == SEL_W'(SEG_COUNT - 1));
  assign hs       = in_valid && in_ready_q;

  for (genvar g = 0; g < FEATURES_PER_CC; g++) begin : g_lane
    qtz_lane #(.LANE_IDX(g)) u_lane (
      .feat_i     (in_features[g*FEAT_W +: FEAT_W]),
      .last_seg_i (last_seg),
      .level_o    (quant_lvl[g])
    );
  end

  // The delay pipe runs every cycle so write strobes reproduce the input gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      seg_cnt_q      <= '0;
      in_ready_q     <= 1'b0;
      im_req_q       <= 1'b0;
      pipe_v_q       <= '0;
      map_q          <= 1'b0;
      sel_q          <= '0;
      busy_q         <= 1'b0;
      levels_ready_q <= 1'b0;
      for (int i = 0; i < FEATURES_PER_CC; i++) im_addr_q[i] <= '0;
      for (int i = 0; i < IM_LAT; i++) pipe_s_q[i] <= '0;
    end else begin
      im_req_q       <= 1'b0;
      levels_ready_q <= 1'b0;
      for (int i = IM_LAT - 1; i >= 1; i--) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_s_q[i] <= pipe_s_q[i-1];
      end
      pipe_v_q[0] <= hs;
      pipe_s_q[0] <= seg_cnt_q;
      map_q       <= pipe_v_q[IM_LAT-1];
      sel_q       <= pipe_s_q[IM_LAT-1];

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FETCH;
            seg_cnt_q  <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        FETCH: begin
          if (hs) begin
            im_req_q  <= 1'b1;
            seg_cnt_q <= seg_cnt_q + 1'b1;
            for (int i = 0; i < FEATURES_PER_CC; i++) im_addr_q[i] <= quant_lvl[i];
            if (last_seg) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (pipe_v_q == '0) begin
            state_q        <= DONE;
            levels_ready_q <= 1'b1;
            busy_q         <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready           = in_ready_q;
  assign im_req             = im_req_q;
  assign im_addr            = im_addr_q;
  assign mapping_hv_segment = map_q;
  assign sel                = sel_q;
  assign busy               = busy_q;
  assign levels_ready       = levels_ready_q;

endmodule

// File: tb/tb_qtz_seg_fetch_ctrl.sv
// Directed bench for qtz_seg_fetch_ctrl: reset, quantization, pad lanes, write timing, gaps and start filtering.
// Expected quantizer values follow QTZ_ROUND_EN when the bench is built with it.
module tb_qtz_seg_fetch_ctrl;
  import hdc_pkg::*;

  logic                              clk;
  logic                              rst;
  logic                              start;
  logic                              in_valid;
  logic                              in_ready;
  logic [FEAT_W*FEATURES_PER_CC-1:0] in_features;
  logic                              im_req;
  logic [LEVEL_W-1:0]                im_addr [0:FEATURES_PER_CC-1];
  logic                              mapping_hv_segment;
  logic [3:0]                        sel;
  logic                              busy;
  logic                              levels_ready;

  int checks = 0;
  int errors = 0;
  int lrCount = 0;

`ifdef QTZ_ROUND_EN
  localparam int EXP_0C = 2;
  localparam int EXP_03 = 0;
  localparam int EXP_04 = 1;
`else
  localparam int EXP_0C = 1;
  localparam int EXP_03 = 0;
  localparam int EXP_04 = 0;
`endif

  qtz_seg_fetch_ctrl #(.IM_LAT(1)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_features        (in_features),
    .im_req             (im_req),
    .im_addr            (im_addr),
    .mapping_hv_segment (mapping_hv_segment),
    .sel                (sel),
    .busy               (busy),
    .levels_ready       (levels_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (levels_ready === 1'b1) lrCount++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic s);
    in_valid = v;
    start    = s;
  endtask

  task automatic setAllLanes(input logic [7:0] val);
    for (int i = 0; i < FEATURES_PER_CC; i++) in_features[i*FEAT_W +: FEAT_W] = val;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_im_req"}, im_req, 0);
    checkOutput({tag, "_wr"}, mapping_hv_segment, 0);
    checkOutput({tag, "_sel"}, sel, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_lr"}, levels_ready, 0);
    checkOutput({tag, "_addr0"}, im_addr[0], 0);
  endtask

  logic [0:17] pat;
  int beats;
  int wrIdx;
  logic prevHs;
  logic v;

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0);
    in_features = '0;
    tick();
    tick();
    checkIdleOutputs("reset");
    rst = 1'b0;

    // in_valid while idle must be ignored
    setAllLanes(8'hFF);
    applyStimulus(1, 0);
    tick();
    checkOutput("idle_in_ready", in_ready, 0);
    checkOutput("idle_im_req", im_req, 0);
    checkOutput("idle_busy", busy, 0);

    applyStimulus(0, 1);
    tick();
    applyStimulus(0, 0);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_in_ready", in_ready, 1);

    // Four beats then an asynchronous reset mid-sample
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0);
      tick();
      checkOutput("abort_im_req", im_req, 1);
      checkOutput("abort_addr0", im_addr[0], 31);
    end
    applyStimulus(0, 0);
    rst = 1'b1;
    #1;
    checkIdleOutputs("midreset");
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_reset_wr", mapping_hv_segment, 0);
    checkOutput("post_reset_busy", busy, 0);

    // Back-to-back sample with start pulses that must be ignored
    applyStimulus(0, 1);
    tick();
    checkOutput("s2_busy", busy, 1);
    for (int k = 0; k < 10; k++) begin
      setAllLanes(8'h00);
      if (k == 0) begin
        in_features[0*FEAT_W +: FEAT_W] = 8'h0C;
        in_features[1*FEAT_W +: FEAT_W] = 8'h03;
        in_features[2*FEAT_W +: FEAT_W] = 8'h04;
        in_features[3*FEAT_W +: FEAT_W] = 8'hFF;
      end else if (k == 1) begin
        in_features[0*FEAT_W +: FEAT_W] = 8'hFF;
      end else if (k == 9) begin
        setAllLanes(8'hFF);
      end
      applyStimulus(1, k == 5);
      tick();
      checkOutput("b2b_im_req", im_req, 1);
      checkOutput("b2b_wr", mapping_hv_segment, k > 0);
      if (k > 0) checkOutput("b2b_sel", sel, k - 1);
      checkOutput("b2b_busy", busy, 1);
      if (k == 0) begin
        checkOutput("q_lane0_0C", im_addr[0], EXP_0C);
        checkOutput("q_lane1_03", im_addr[1], EXP_03);
        checkOutput("q_lane2_04", im_addr[2], EXP_04);
        checkOutput("q_lane3_FF", im_addr[3], 31);
      end else if (k == 1) begin
        checkOutput("q_lane0_FF", im_addr[0], 31);
      end else if (k == 9) begin
        for (int i = 0; i < FEATURES_PER_CC; i++)
          checkOutput($sformatf("pad_lane%0d", i), im_addr[i], (i < PAD_FIRST_LANE) ? 31 : 0);
      end
    end
    applyStimulus(0, 0);
    in_features[0*FEAT_W +: FEAT_W] = 8'h00;
    tick();
    checkOutput("drain_wr", mapping_hv_segment, 1);
    checkOutput("drain_sel", sel, 9);
    checkOutput("drain_im_req", im_req, 0);
    checkOutput("drain_lr", levels_ready, 0);
    checkOutput("drain_in_ready", in_ready, 0);
    checkOutput("hold_addr0", im_addr[0], 31);
    checkOutput("hold_addr61", im_addr[61], 0);
    tick();
    checkOutput("done_lr", levels_ready, 1);
    checkOutput("done_wr", mapping_hv_segment, 0);
    checkOutput("done_busy", busy, 0);
    applyStimulus(0, 1);
    tick();
    checkOutput("done_start_lr", levels_ready, 0);
    checkOutput("done_start_busy", busy, 0);
    checkOutput("done_start_in_ready", in_ready, 0);
    tick();
    applyStimulus(0, 0);
    checkOutput("late_start_busy", busy, 1);
    checkOutput("late_start_in_ready", in_ready, 1);

    // Gapped beats: writes must trail each request by one cycle with identical gaps
    pat = 18'b100110000110110111;
    beats = 0;
    wrIdx = 0;
    prevHs = 1'b0;
    for (int c = 0; c < 40 && beats < 10; c++) begin
      v = (c < 18) ? pat[c] : 1'b1;
      applyStimulus(v, 0);
      tick();
      checkOutput("gap_im_req", im_req, v);
      checkOutput("gap_wr", mapping_hv_segment, prevHs);
      if (prevHs) begin
        checkOutput("gap_sel", sel, wrIdx);
        wrIdx++;
      end
      prevHs = v;
      if (v) beats++;
    end
    applyStimulus(0, 0);
    checkOutput("gap_budget", beats, 10);
    tick();
    checkOutput("gap_last_wr", mapping_hv_segment, 1);
    checkOutput("gap_last_sel", sel, 9);
    tick();
    checkOutput("gap_lr", levels_ready, 1);
    checkOutput("gap_wr_off", mapping_hv_segment, 0);
    tick();
    checkOutput("lr_pulse_count", lrCount, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
